// File: rtl/game_credit_ctrl.sv
// game_credit_ctrl: credit/time controller for a coin-operated game station.
// Deposits from the payment front-end add to a saturating credit balance,
// play deducts a normal or boost cost per cycle, and registered lamp flags
// (yellow = low credit, red = insufficient credit) drive the station lamps.
// Optional macro GAME_CREDIT_SPENT_EN adds a saturating 16-bit running total
// of deducted credits on output 'spent'.
module game_credit_ctrl #(
  parameter int W          = 10,
  parameter int NORM_COST  = 1,
  parameter int BOOST_COST = 2,
  parameter int WARN_LVL   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] money,
  input  logic         set,
  input  logic         boost,
  input  logic         pause,
  output logic [W-1:0] remain,
  output logic         yellow,
  output logic         red,
  output logic         ovf,
`ifdef GAME_CREDIT_SPENT_EN
  output logic [15:0]  spent,
`endif
  output logic         play
);

  localparam logic [W-1:0] NORM_C  = W'(NORM_COST);
  localparam logic [W-1:0] BOOST_C = W'(BOOST_COST);
  localparam logic [W-1:0] WARN_C  = W'(WARN_LVL);
  localparam logic [W:0]   MAX_EXT = {1'b0, {W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] remain_q, remain_d;
  logic         yellow_q, yellow_d;
  logic         red_q, red_d;
  logic         ovf_q, ovf_d;
  logic         play_q, play_d;

  logic [W-1:0] cost;
  logic [W-1:0] add;
  logic [W-1:0] ded;
  logic [W:0]   sum;

  // Credit arithmetic, lamp flags and next play state, all from registered values.
  always_comb begin
    cost     = boost ? BOOST_C : NORM_C;
    add      = set ? money : '0;
    // Deduction only ever draws on credit already held; never a partial charge.
    ded      = (!pause && (remain_q >= cost)) ? cost : '0;
    sum      = {1'b0, remain_q} - {1'b0, ded} + {1'b0, add};
    ovf_d    = (sum > MAX_EXT);
    remain_d = ovf_d ? MAX_EXT[W-1:0] : sum[W-1:0];
    red_d    = (remain_d < cost);
    yellow_d = !red_d && (remain_d <= WARN_C);

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if ((remain_d >= cost) && !pause)      state_d = PLAY;
        else if (pause && (remain_d != '0))    state_d = PAUSED;
      end
      PLAY: begin
        if (pause)                             state_d = PAUSED;
        else if (remain_d < NORM_C)            state_d = IDLE;
      end
      PAUSED: begin
        if (!pause) state_d = (remain_d >= cost) ? PLAY : IDLE;
      end
      default:                                 state_d = IDLE;
    endcase
    play_d = (state_d == PLAY);
  end

  // Register state and all outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      yellow_q <= 1'b0;
      red_q    <= 1'b0;
      ovf_q    <= 1'b0;
      play_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      ovf_q    <= ovf_d;
      play_q   <= play_d;
    end
  end

  assign remain = remain_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign ovf    = ovf_q;
  assign play   = play_q;

`ifdef GAME_CREDIT_SPENT_EN
  // Wide enough that one deduction can never wrap the intermediate sum.
  localparam int SPW = (W > 16) ? (W + 1) : 17;

  logic [15:0]    spent_q, spent_d;
  logic [SPW-1:0] spent_sum;

  // Running total of deducted credits, clipped at all-ones.
  always_comb begin
    spent_sum = SPW'(spent_q) + SPW'(ded);
    spent_d   = (spent_sum > SPW'(17'h0FFFF)) ? 16'hFFFF : spent_sum[15:0];
  end

  // Spent total advances in the same cycle as the balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spent_q <= '0;
    else        spent_q <= spent_d;
  end

  assign spent = spent_q;
`endif

endmodule

// File: tb/tb_game_credit_ctrl.sv
// tb_game_credit_ctrl: directed scoreboard bench for game_credit_ctrl
// (W=10, NORM_COST=1, BOOST_COST=2, WARN_LVL=10). Define
// GAME_CREDIT_SPENT_EN to also check the spent total.
module tb_game_credit_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] money = '0;
  logic         set = 1'b0;
  logic         boost = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] remain;
  logic         yellow, red, ovf, play;
`ifdef GAME_CREDIT_SPENT_EN
  logic [15:0]  spent;
`endif

  typedef struct {
    int remain;
    int yellow;
    int red;
    int ovf;
    int play;
    int spent;   // -1: not checked for this step
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  game_credit_ctrl #(
    .W(W), .NORM_COST(1), .BOOST_COST(2), .WARN_LVL(10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .money  (money),
    .set    (set),
    .boost  (boost),
    .pause  (pause),
    .remain (remain),
    .yellow (yellow),
    .red    (red),
    .ovf    (ovf),
`ifdef GAME_CREDIT_SPENT_EN
    .spent  (spent),
`endif
    .play   (play)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input int y, input int rd, input int o,
                      input int p, input int s);
    exp_t e;
    e.remain = r; e.yellow = y; e.red = rd; e.ovf = o; e.play = p; e.spent = s;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_remain"}, int'(remain), e.remain);
    chk({tag, "_yellow"}, int'(yellow), e.yellow);
    chk({tag, "_red"},    int'(red),    e.red);
    chk({tag, "_ovf"},    int'(ovf),    e.ovf);
    chk({tag, "_play"},   int'(play),   e.play);
`ifdef GAME_CREDIT_SPENT_EN
    if (e.spent >= 0) chk({tag, "_spent"}, int'(spent), e.spent);
`endif
    $display("txn %s: remain=%0d yellow=%0d red=%0d ovf=%0d play=%0d",
             tag, remain, yellow, red, ovf, play);
  endtask

  // Drive one cycle of inputs (called at posedge+1), then check one clock later.
  task automatic step(input string tag, input bit s, input int m, input bit b,
                      input bit p, input int r, input int y, input int rd,
                      input int o, input int pl, input int sp);
    set = s; money = W'(m); boost = b; pause = p;
    push(r, y, rd, o, pl, sp);
    @(posedge clk); #1;
    pop_cmp(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set = 1'b0; money = '0; boost = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(0, 0, 0, 0, 0, 0);
    pop_cmp("in_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // 1: idle after reset
    step("idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // 2: deposit 12 then count down; yellow from 10
    step("dep12", 1, 12, 0, 0, 12, 0, 0, 0, 1, 0);
    step("cnt11", 0, 0, 0, 0, 11, 0, 0, 0, 1, 1);
    for (int r = 10; r >= 3; r--)
      step($sformatf("cnt%0d", r), 0, 0, 0, 0, r, 1, 0, 0, 1, 12 - r);

    // 3: boost from 3, then starved in boost, then drop boost
    step("boost3", 0, 0, 1, 0, 1, 0, 1, 0, 1, 11);
    step("starve_a", 0, 0, 1, 0, 1, 0, 1, 0, 1, 11);
    step("starve_b", 0, 0, 1, 0, 1, 0, 1, 0, 1, 11);
    step("drop_boost", 0, 0, 0, 0, 0, 0, 1, 0, 0, 12);

    // 4: saturation
    step("dep1021", 1, 1021, 0, 0, 1021, 0, 0, 0, 1, 12);
    step("cnt1020", 0, 0, 0, 0, 1020, 0, 0, 0, 1, 13);
    step("sat", 1, 10, 0, 0, 1023, 0, 0, 1, 1, 14);
    step("post_sat", 0, 0, 0, 0, 1022, 0, 0, 0, 1, 15);

    // 5: pause with deposit in the middle
    do_reset();
    step("dep6", 1, 6, 0, 0, 6, 1, 0, 0, 1, 0);
    step("cnt5", 0, 0, 0, 0, 5, 1, 0, 0, 1, 1);
    step("pause1", 0, 0, 0, 1, 5, 1, 0, 0, 0, 1);
    step("pause2", 1, 3, 0, 1, 8, 1, 0, 0, 0, 1);
    step("pause3", 0, 0, 0, 1, 8, 1, 0, 0, 0, 1);
    step("unpause", 0, 0, 0, 0, 7, 1, 0, 0, 1, 2);
    step("dep_zero", 1, 0, 0, 0, 6, 1, 0, 0, 1, 3);
    step("boost_tog", 0, 0, 1, 0, 4, 1, 0, 0, 1, 5);
    step("dep37", 1, 37, 0, 0, 40, 0, 0, 0, 1, 6);

    // 6: asynchronous reset mid-cycle while remain=40
    set = 1'b0; money = '0; boost = 1'b0; pause = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    push(0, 0, 0, 0, 0, 0);
    pop_cmp("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("dep10", 1, 10, 0, 0, 10, 1, 0, 0, 1, 0);
    step("play9", 0, 0, 0, 0, 9, 1, 0, 0, 1, 1);
    step("play8", 0, 0, 0, 0, 8, 1, 0, 0, 1, 2);
    step("play7", 0, 0, 0, 0, 7, 1, 0, 0, 1, 3);

    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
